// File: rtl/config_preset_loader_pkg.sv
// Shared ZXUNO configuration constants: register addresses, preset table and
// readback compare masks used by the preset loader.
package config_preset_loader_pkg;

  localparam logic [7:0] ADDR_MASTERCONF = 8'h00;
  localparam logic [7:0] ADDR_MASTERMAPPER = 8'h01;
  localparam logic [7:0] ADDR_DEVOPTIONS = 8'h0E;
  localparam logic [7:0] ADDR_DEVOPTS2 = 8'h0F;

  // Bits outside these masks are forced by core features and may read back differently.
  localparam logic [7:0] MASK_DEVOPTIONS = 8'h3D;
  localparam logic [7:0] MASK_DEVOPTS2 = 8'hF0;

  typedef enum logic [1:0] {
    PRESET_48K      = 2'd0,
    PRESET_128K     = 2'd1,
    PRESET_PLUS2A   = 2'd2,
    PRESET_48K_NOAY = 2'd3
  } preset_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0] devoptions;
    logic [7:0] devopts2;
  } preset_t;

  function automatic preset_t preset_lookup(input logic [1:0] sel);
    preset_t row;
    case (preset_e'(sel))
      PRESET_48K:      row = '{devoptions: 8'h3C, devopts2: 8'h06};
      PRESET_128K:     row = '{devoptions: 8'h28, devopts2: 8'h00};
      PRESET_PLUS2A:   row = '{devoptions: 8'h00, devopts2: 8'h00};
      PRESET_48K_NOAY: row = '{devoptions: 8'h3D, devopts2: 8'h06};
      default:         row = '{devoptions: 8'h3C, devopts2: 8'h06};
    endcase
    return row;
  endfunction

endpackage

// File: rtl/config_preset_loader_if.sv
// Arbitrated ZXUNO register bus: the loader side drives address/data/strobes,
// the register file returns readback data with its output-enable.
interface config_preset_loader_if;
  logic [7:0] zxuno_addr;
  logic       zxuno_regwr;
  logic       zxuno_regrd;
  logic [7:0] zxuno_din;
  logic [7:0] rd_data;
  logic       rd_oe;

  modport master (
    output zxuno_addr, zxuno_regwr, zxuno_regrd, zxuno_din,
    input  rd_data, rd_oe
  );

  modport slave (
    input  zxuno_addr, zxuno_regwr, zxuno_regrd, zxuno_din,
    output rd_data, rd_oe
  );
endinterface

// File: rtl/config_preset_loader_preset_rom.sv
// Combinational preset table: selects the register address, value and readback
// mask for one entry of the chosen preset.
module preset_rom
  import config_preset_loader_pkg::*;
(
  input  logic [1:0] preset,
  input  logic       idx,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic [7:0] mask
);

  preset_t row_s;

  // Entry 0 is DEVOPTIONS, entry 1 is DEVOPTS2.
  always_comb begin
    row_s = preset_lookup(preset);
    if (idx == 1'b0) begin
      addr = ADDR_DEVOPTIONS;
      data = row_s.devoptions;
      mask = MASK_DEVOPTIONS;
    end else begin
      addr = ADDR_DEVOPTS2;
      data = row_s.devopts2;
      mask = MASK_DEVOPTS2;
    end
  end

endmodule

// File: rtl/config_preset_loader.sv
// Preset loader: writes and verifies a two-register preset on the ZXUNO bus,
// yielding the bus to the CPU whenever it issues an access.
module config_preset_loader
  import config_preset_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_regwr,
  input  logic       cpu_regrd,
  input  logic [7:0] cpu_din,
  input  logic       preset_req,
  input  logic [1:0] preset_sel,
  config_preset_loader_if.master bus,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       aborted
);

  state_e     state_q, state_d;
  logic       idx_q, idx_d;
  logic [1:0] preset_q, preset_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       aborted_q, aborted_d;

  logic       cpu_act_s;
  logic       abort_s;
  logic       ld_wr_s;
  logic       ld_rd_s;
  logic       mismatch_s;
  logic [7:0] rom_addr_s;
  logic [7:0] rom_data_s;
  logic [7:0] rom_mask_s;

  preset_rom u_preset_rom (
    .preset (preset_q),
    .idx    (idx_q),
    .addr   (rom_addr_s),
    .data   (rom_data_s),
    .mask   (rom_mask_s)
  );

  assign cpu_act_s  = cpu_regwr | cpu_regrd;
  assign abort_s    = busy_q & cpu_regwr &
                      ((cpu_addr == ADDR_DEVOPTIONS) | (cpu_addr == ADDR_DEVOPTS2));
  assign mismatch_s = ((bus.rd_data ^ rom_data_s) & rom_mask_s) != 8'h00;

  // Next-state and loader access decode; a CPU access always wins the cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    preset_d  = preset_q;
    err_d     = err_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    ld_wr_s   = 1'b0;
    ld_rd_s   = 1'b0;
    if (abort_s) begin
      state_d   = ST_IDLE;
      idx_d     = 1'b0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (preset_req) begin
            preset_d = preset_sel;
            err_d    = 1'b0;
            idx_d    = 1'b0;
            state_d  = ST_WR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WR: begin
          if (!cpu_act_s) begin
            ld_wr_s = 1'b1;
            state_d = ST_RD;
          end else begin
            state_d = ST_WR;
          end
        end
        ST_RD: begin
          if (!cpu_act_s) begin
            ld_rd_s = 1'b1;
            if (!bus.rd_oe || mismatch_s) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            state_d = ST_NEXT;
          end else begin
            state_d = ST_RD;
          end
        end
        ST_NEXT: begin
          if (idx_q == 1'b0) begin
            idx_d   = 1'b1;
            state_d = ST_WR;
          end else begin
            done_d  = ~err_q;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_WR) | (state_d == ST_RD) | (state_d == ST_NEXT);
  end

  // Bus arbiter: CPU pass-through has zero latency; otherwise the loader or idle zeros.
  always_comb begin
    bus.zxuno_addr  = 8'h00;
    bus.zxuno_din   = 8'h00;
    bus.zxuno_regwr = 1'b0;
    bus.zxuno_regrd = 1'b0;
    if (cpu_act_s) begin
      bus.zxuno_addr  = cpu_addr;
      bus.zxuno_din   = cpu_din;
      bus.zxuno_regwr = cpu_regwr;
      bus.zxuno_regrd = cpu_regrd;
    end else if (ld_wr_s && !rst) begin
      bus.zxuno_addr  = rom_addr_s;
      bus.zxuno_din   = rom_data_s;
      bus.zxuno_regwr = 1'b1;
    end else if (ld_rd_s && !rst) begin
      bus.zxuno_addr  = rom_addr_s;
      bus.zxuno_regrd = 1'b1;
    end else begin
      bus.zxuno_addr  = 8'h00;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 1'b0;
      preset_q  <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      preset_q  <= preset_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_config_preset_loader.sv
// Bench for config_preset_loader: directed scenarios plus randomized CPU
// contention, checked against a transaction-level model of the preset sequence.
module tb_config_preset_loader;

  logic       clk;
  logic       rst;
  logic [7:0] cpu_addr;
  logic       cpu_regwr;
  logic       cpu_regrd;
  logic [7:0] cpu_din;
  logic       preset_req;
  logic [1:0] preset_sel;
  logic       busy, done, err, aborted;

  int checks;
  int errors;

  // Register file model behaviour knobs.
  logic [7:0] regs [256];
  logic [7:0] force_or_0e;
  logic       ovr_en;
  logic [7:0] ovr_addr;
  logic [7:0] ovr_val;
  logic       oe_ok;

  config_preset_loader_if bus_if ();

  config_preset_loader dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_regwr  (cpu_regwr),
    .cpu_regrd  (cpu_regrd),
    .cpu_din    (cpu_din),
    .preset_req (preset_req),
    .preset_sel (preset_sel),
    .bus        (bus_if),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .aborted    (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_if.zxuno_regwr)
      regs[bus_if.zxuno_addr] <= bus_if.zxuno_din |
                                 ((bus_if.zxuno_addr == 8'h0E) ? force_or_0e : 8'h00);
  end

  always_comb begin
    bus_if.rd_data = regs[bus_if.zxuno_addr];
    if (ovr_en && (bus_if.zxuno_addr == ovr_addr)) bus_if.rd_data = ovr_val;
    bus_if.rd_oe = bus_if.zxuno_regrd & oe_ok;
  end

  function automatic logic [7:0] tab_val(input logic [1:0] sel, input int e);
    logic [7:0] v;
    case ({sel, e[0]})
      3'b000: v = 8'h3C;  3'b001: v = 8'h06;
      3'b010: v = 8'h28;  3'b011: v = 8'h00;
      3'b100: v = 8'h00;  3'b101: v = 8'h00;
      3'b110: v = 8'h3D;  default: v = 8'h06;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] tab_addr(input int e);
    return (e == 0) ? 8'h0E : 8'h0F;
  endfunction

  function automatic logic [7:0] tab_mask(input int e);
    return (e == 0) ? 8'h3D : 8'hF0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit req, input logic [1:0] sel, input bit wr, input bit rd,
                       input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    preset_req = req;
    preset_sel = sel;
    cpu_regwr  = wr;
    cpu_regrd  = rd;
    cpu_addr   = a;
    cpu_din    = d;
    #4;
  endtask

  function automatic logic [31:0] bus_word();
    return {14'd0, bus_if.zxuno_addr, bus_if.zxuno_din, bus_if.zxuno_regwr, bus_if.zxuno_regrd};
  endfunction

  // One full preset sequence; pat bit k means a CPU access in cycle k after the request.
  task automatic run_seq(input logic [1:0] sel, input logic [31:0] pat, input logic [7:0] f_or,
                         input bit ovr, input logic [7:0] o_a, input logic [7:0] o_v,
                         input bit oe, input string tag);
    int         op;
    bit         finished;
    bit         exp_err;
    bit         cpu, cwr, req;
    logic [7:0] a, d, rb, ca, cd;
    logic [31:0] exp_bus;
    force_or_0e = f_or; ovr_en = ovr; ovr_addr = o_a; ovr_val = o_v; oe_ok = oe;
    exp_err = 1'b0;
    for (int e = 0; e < 2; e++) begin
      a  = tab_addr(e);
      d  = tab_val(sel, e);
      rb = d | ((a == 8'h0E) ? f_or : 8'h00);
      if (ovr && (a == o_a)) rb = o_v;
      if (!oe || (((rb ^ d) & tab_mask(e)) != 8'h00)) exp_err = 1'b1;
    end
    op = 0;
    finished = 1'b0;
    for (int k = 0; k < 64 && !finished; k++) begin
      cpu = (k > 0 && k < 32) ? pat[k] : 1'b0;
      cwr = cpu && ($urandom_range(0, 1) == 1);
      ca  = cwr ? (8'h40 + 8'($urandom_range(0, 63))) : 8'($urandom);
      cd  = 8'($urandom);
      req = (k == 0) || (op < 6 && $urandom_range(0, 3) == 0);
      drive(req, (k == 0) ? sel : 2'($urandom), cwr, cpu && !cwr, ca, cd);
      if (k == 0) begin
        check($sformatf("%s.start.bus", tag), bus_word(), 32'd0);
        check($sformatf("%s.start.flags", tag), {29'd0, busy, done, aborted}, 32'd0);
      end else begin
        if (cpu) exp_bus = {14'd0, ca, cd, cwr, !cwr};
        else if (op == 0 || op == 3) exp_bus = {14'd0, tab_addr(op / 3), tab_val(sel, op / 3), 2'b10};
        else if (op == 1 || op == 4) exp_bus = {14'd0, tab_addr(op / 3), 8'h00, 2'b01};
        else exp_bus = 32'd0;
        check($sformatf("%s.k%0d.bus", tag, k), bus_word(), exp_bus);
        if (op < 6) begin
          check($sformatf("%s.k%0d.flags", tag, k), {29'd0, busy, done, aborted}, 32'b100);
          if (op == 2 || op == 5 || !cpu) op++;
        end else begin
          check($sformatf("%s.k%0d.final", tag, k), {29'd0, busy, done, aborted},
                {29'd0, 1'b0, !exp_err, 1'b0});
          check($sformatf("%s.err", tag), {31'd0, err}, {31'd0, exp_err});
          finished = 1'b1;
        end
      end
    end
    if (!finished) check($sformatf("%s.timeout", tag), 32'd1, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    force_or_0e = 8'h00; ovr_en = 1'b0; ovr_addr = 8'h00; ovr_val = 8'h00; oe_ok = 1'b1;
    preset_req = 1'b0; preset_sel = 2'd0; cpu_regwr = 1'b0;
    // Reset: outputs zero, CPU still passes through.
    rst = 1'b1; cpu_regrd = 1'b1; cpu_addr = 8'h33; cpu_din = 8'h77;
    #3;
    check("rst.pass", bus_word(), {14'd0, 8'h33, 8'h77, 2'b01});
    check("rst.flags", {28'd0, busy, done, err, aborted}, 32'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h12, 8'h34);
    check("rst.idle_bus", bus_word(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_seq(2'd1, 32'h0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, "sel1");
    run_seq(2'd0, 32'h0, 8'h02, 1'b0, 8'h00, 8'h00, 1'b1, "sel0_forced");
    run_seq(2'd2, 32'h0, 8'h00, 1'b1, 8'h0F, 8'h80, 1'b1, "sel2_bad");
    run_seq(2'd1, 32'h0000_000E, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, "sel1_stall3");

    // Abort by CPU write to DEVOPTS2 during the first readback.
    force_or_0e = 8'h00; ovr_en = 1'b0; oe_ok = 1'b1;
    drive(1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("abort1.wr0", bus_word(), {14'd0, 8'h0E, 8'h3D, 2'b10});
    drive(1'b0, 2'd0, 1'b1, 1'b0, 8'h0F, 8'hA5);
    check("abort1.cpu", bus_word(), {14'd0, 8'h0F, 8'hA5, 2'b10});
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("abort1.pulse", {29'd0, busy, done, aborted}, 32'b001);
    check("abort1.bus", bus_word(), 32'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("abort1.after", {29'd0, busy, done, aborted}, 32'b000);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("abort1.bus2", bus_word(), 32'd0);
    check("abort1.reg0f", {24'd0, regs[8'h0F]}, 32'hA5);

    // Abort after a readback error: err must survive, no done.
    ovr_en = 1'b1; ovr_addr = 8'h0F; ovr_val = 8'h80;
    drive(1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 1; k < 6; k++) drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 2'd0, 1'b1, 1'b0, 8'h0E, 8'h11);
    check("abort2.err_set", {31'd0, err}, 32'd1);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("abort2.pulse", {28'd0, busy, done, err, aborted}, 32'b0011);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("abort2.after", {28'd0, busy, done, err, aborted}, 32'b0010);
    ovr_en = 1'b0;

    // Reset in the middle of the first readback.
    drive(1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    preset_req = 1'b0;
    #2;
    check("midrst.rd", bus_word(), {14'd0, 8'h0E, 8'h00, 2'b01});
    rst = 1'b1;
    #1;
    check("midrst.bus", bus_word(), 32'd0);
    check("midrst.flags", {28'd0, busy, done, err, aborted}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_seq(2'd0, 32'h0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, "after_rst");

    for (int i = 0; i < 10; i++) begin
      run_seq(2'($urandom_range(0, 3)), $urandom & $urandom & 32'hFFFF_FFFE,
              ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00,
              $urandom_range(0, 3) == 0, ($urandom_range(0, 1) == 1) ? 8'h0E : 8'h0F,
              8'($urandom), $urandom_range(0, 5) != 0, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
